// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider: default datapath width,
//   iteration-counter width, CLA slice width and the FSM state type.
//   Imported by cla_inner, div_sub_stage and seq_divider.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;
  localparam int CLA_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/cla_inner.sv
// -----------------------------------------------------------------------------
// cla_inner
//   8-bit carry-lookahead adder slice. Every internal carry is formed directly
//   from generate/propagate terms and the slice carry-in (sum-of-products
//   lookahead form), so no carry depends on a lower-order carry inside the
//   slice.
// Ports
//   i_a, i_b  in  CLA_W  addends
//   i_cin     in  1      carry in
//   o_sum     out CLA_W  sum
//   o_cout    out 1      carry out
// -----------------------------------------------------------------------------
module cla_inner
  import div_pkg::*;
(
  input  logic [CLA_W-1:0] i_a,
  input  logic [CLA_W-1:0] i_b,
  input  logic             i_cin,
  output logic [CLA_W-1:0] o_sum,
  output logic             o_cout
);

  logic [CLA_W-1:0] w_g;
  logic [CLA_W-1:0] w_p;
  logic [CLA_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    logic carry;
    logic prop;
    // NOTE: every variable written here gets a value first on every pass,
    // otherwise synthesis would infer a latch to hold the old value.
    w_c    = '0;
    carry  = 1'b0;
    prop   = 1'b1;
    w_c[0] = i_cin;
    for (int i = 0; i < CLA_W; i++) begin
      // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
      carry = 1'b0;
      prop  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry = carry | (prop & w_g[j]);
        prop  = prop & w_p[j];
      end
      w_c[i+1] = carry | (prop & i_cin);
    end
  end

  assign o_sum  = w_p ^ w_c[CLA_W-1:0];
  assign o_cout = w_c[CLA_W];

endmodule

// File: rtl/div_sub_stage.sv
// -----------------------------------------------------------------------------
// div_sub_stage
//   Combinational (WIDTH+1)-bit subtractor o_diff = i_a - i_b computed as
//   i_a + ~i_b + 1 through chained cla_inner slices; the extra top bit is a
//   single full-adder cell. o_borrow is high when i_a < i_b (unsigned), i.e.
//   the trial result is negative. Also used as a negator: 0 - x.
// Ports
//   i_a       in  WIDTH+1  minuend
//   i_b       in  WIDTH+1  subtrahend
//   o_diff    out WIDTH+1  difference (mod 2^(WIDTH+1))
//   o_borrow  out 1        minuend < subtrahend
// WIDTH must be a multiple of CLA_W.
// -----------------------------------------------------------------------------
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff,
  output logic           o_borrow
);

  localparam int N_SLICES = WIDTH / CLA_W;

  logic [WIDTH:0]    w_b_n;
  logic [N_SLICES:0] w_carry;
  logic              w_cout;

  assign w_b_n      = ~i_b;
  assign w_carry[0] = 1'b1;  // the +1 of two's-complement subtraction

  for (genvar gi = 0; gi < N_SLICES; gi++) begin : g_slice
    cla_inner u_cla (
      .i_a    (i_a[gi*CLA_W +: CLA_W]),
      .i_b    (w_b_n[gi*CLA_W +: CLA_W]),
      .i_cin  (w_carry[gi]),
      .o_sum  (o_diff[gi*CLA_W +: CLA_W]),
      .o_cout (w_carry[gi+1])
    );
  end

  assign o_diff[WIDTH] = i_a[WIDTH] ^ w_b_n[WIDTH] ^ w_carry[N_SLICES];
  assign w_cout        = (i_a[WIDTH] & w_b_n[WIDTH]) |
                         (i_a[WIDTH] & w_carry[N_SLICES]) |
                         (w_b_n[WIDTH] & w_carry[N_SLICES]);
  // For A + ~B + 1 a carry out means no borrow.
  assign o_borrow      = ~w_cout;

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multicycle restoring integer divider. One quotient bit per clock through a
//   CLA trial subtractor; fixed latency of WIDTH+2 edges from the start edge
//   to the edge that ends the one-cycle data_resultRDY pulse.
//   FSM: IDLE -> ITER (WIDTH edges) -> FIX -> DONE -> IDLE.
//   A ctrl_DIV pulse in any state (re)captures operands and restarts; an
//   aborted division never raises data_resultRDY.
// Configuration macro
//   DIV_SIGNED_EN  defined  : two's-complement operands, quotient truncates
//                             toward zero, remainder takes dividend's sign,
//                             MIN_INT / -1 gives MIN_INT, 0, exception.
//                  undefined: unsigned operands, exception only on div-by-0.
// Ports
//   clock           in   1      rising-edge clock
//   resetn          in   1      asynchronous active-low reset
//   ctrl_DIV        in   1      start pulse, operands sampled on same edge
//   data_operandA   in   WIDTH  dividend
//   data_operandB   in   WIDTH  divisor
//   data_result     out  WIDTH  quotient
//   data_remainder  out  WIDTH  remainder
//   data_exception  out  1      divide-by-zero / signed overflow
//   data_resultRDY  out  1      one-cycle pulse, outputs valid
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_div0;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic             r_exc;
  logic             r_rdy;

  // ---------------------------------------------------------------------------
  // Trial subtraction. The full partial remainder R is kept (WIDTH+1-bit
  // trial) so divisors with the top bit set divide exactly.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] w_trial_a;
  logic [WIDTH:0] w_trial_b;
  logic [WIDTH:0] w_trial_diff;
  logic           w_trial_borrow;

  assign w_trial_a = {r_rem, r_quo[WIDTH-1]};
  assign w_trial_b = {1'b0, r_divisor};

  div_sub_stage #(.WIDTH(WIDTH)) u_trial (
    .i_a      (w_trial_a),
    .i_b      (w_trial_b),
    .o_diff   (w_trial_diff),
    .o_borrow (w_trial_borrow)
  );

  // ---------------------------------------------------------------------------
  // Operand conditioning and sign fix-up
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_q_signed;
  logic [WIDTH-1:0] w_r_signed;
  logic             w_ovf;
  logic             w_unused;

`ifdef DIV_SIGNED_EN
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_ovf;
  logic [WIDTH-1:0] w_neg0_in;
  logic [WIDTH-1:0] w_neg1_in;
  logic [WIDTH:0]   w_neg0_diff;
  logic [WIDTH:0]   w_neg1_diff;
  logic             w_neg0_borrow;
  logic             w_neg1_borrow;

  // The two negators serve the operand abs() on a start edge and the result
  // negation in FIX. A start in FIX aborts, so the FIX values are not needed
  // then and the operand path can take priority.
  assign w_neg0_in = ctrl_DIV ? data_operandA : r_quo;
  assign w_neg1_in = ctrl_DIV ? data_operandB : r_rem;

  div_sub_stage #(.WIDTH(WIDTH)) u_neg0 (
    .i_a      ('0),
    .i_b      ({1'b0, w_neg0_in}),
    .o_diff   (w_neg0_diff),
    .o_borrow (w_neg0_borrow)
  );

  div_sub_stage #(.WIDTH(WIDTH)) u_neg1 (
    .i_a      ('0),
    .i_b      ({1'b0, w_neg1_in}),
    .o_diff   (w_neg1_diff),
    .o_borrow (w_neg1_borrow)
  );

  assign w_abs_a    = data_operandA[WIDTH-1] ? w_neg0_diff[WIDTH-1:0] : data_operandA;
  assign w_abs_b    = data_operandB[WIDTH-1] ? w_neg1_diff[WIDTH-1:0] : data_operandB;
  assign w_q_signed = (r_sign_a ^ r_sign_b) ? w_neg0_diff[WIDTH-1:0] : r_quo;
  assign w_r_signed = r_sign_a ? w_neg1_diff[WIDTH-1:0] : r_rem;
  assign w_ovf      = r_ovf;
  assign w_unused   = ^{w_trial_diff[WIDTH], w_neg0_diff[WIDTH], w_neg1_diff[WIDTH],
                        w_neg0_borrow, w_neg1_borrow};

  // Sign/overflow flags change only when a new division is captured.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (ctrl_DIV) begin
      r_sign_a <= data_operandA[WIDTH-1];
      r_sign_b <= data_operandB[WIDTH-1];
      r_ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
    end
  end
`else
  assign w_abs_a    = data_operandA;
  assign w_abs_b    = data_operandB;
  assign w_q_signed = r_quo;
  assign w_r_signed = r_rem;
  assign w_ovf      = 1'b0;
  assign w_unused   = w_trial_diff[WIDTH];
`endif

  // Final values loaded into the output registers on the FIX->DONE edge.
  logic [WIDTH-1:0] w_fix_result;
  logic [WIDTH-1:0] w_fix_rem;
  logic             w_fix_exc;

  always_comb begin
    w_fix_result = w_q_signed;
    w_fix_rem    = w_r_signed;
    w_fix_exc    = 1'b0;
    if (r_div0) begin
      w_fix_result = '0;
      w_fix_rem    = '0;
      w_fix_exc    = 1'b1;
    end else if (w_ovf) begin
      w_fix_result = {1'b1, {(WIDTH-1){1'b0}}};
      w_fix_rem    = '0;
      w_fix_exc    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, counter, shift registers and output registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) assignments so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_div0      <= 1'b0;
      r_result    <= '0;
      r_remainder <= '0;
      r_exc       <= 1'b0;
      r_rdy       <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (ctrl_DIV) begin
        // Start or restart from any state; a pulse already high in DONE
        // still completes this cycle.
        r_state   <= ITER;
        r_count   <= '0;
        r_rem     <= '0;
        r_quo     <= w_abs_a;
        r_divisor <= w_abs_b;
        r_div0    <= (data_operandB == '0);
      end else begin
        unique case (r_state)
          IDLE: r_state <= IDLE;
          ITER: begin
            if (w_trial_borrow) begin
              r_rem <= w_trial_a[WIDTH-1:0];
            end else begin
              r_rem <= w_trial_diff[WIDTH-1:0];
            end
            r_quo   <= {r_quo[WIDTH-2:0], ~w_trial_borrow};
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) begin
              r_state <= FIX;
            end
          end
          FIX: begin
            r_result    <= w_fix_result;
            r_remainder <= w_fix_rem;
            r_exc       <= w_fix_exc;
            r_rdy       <= 1'b1;
            r_state     <= DONE;
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_remainder = r_remainder;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=32). Expected values come from
//   a plain-arithmetic reference model; latency is counted in clock edges
//   from the start edge. Honours DIV_SIGNED_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clock;
  logic         resetn;
  logic         ctrl_DIV;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         exc;
  logic         rdy;

  int n_checks;
  int n_fail;

  seq_divider #(.WIDTH(W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (result),
    .data_remainder (remainder),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: quotient/remainder/exception from arithmetic rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic e);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = 0; r = 0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0; e = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb; e = 1'b0;
    end
`else
    if (b == 0) begin
      q = 0; r = 0; e = 1'b1;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
`endif
  endfunction

  // Drive a start pulse from the current negedge; returns at the next negedge
  // (one edge after the start edge).
  task automatic launch_now(input logic [W-1:0] a, input logic [W-1:0] b);
    op_a     = a;
    op_b     = b;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    launch_now(a, b);
  endtask

  // Counts edges since the start edge until RDY is seen (bounded).
  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!rdy && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    ctrl_DIV = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({result, remainder, exc, rdy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%h r=%h e=%b rdy=%b, need all 0", result, remainder, exc, rdy);
    end
    resetn = 1'b1;
    @(negedge clock);
    n_checks++;
    if (rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_rdy: got %b need 0", rdy);
    end
  endtask

  task automatic test_basic;
    int lat;
    launch(32'd100, 32'd7);
    wait_rdy(lat);
    n_checks++;
    if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d need %0d", lat, LAT); end
    n_checks++;
    if (result !== 32'd14 || remainder !== 32'd2 || exc !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_100_7: got q=%0d r=%0d e=%b need q=14 r=2 e=0", result, remainder, exc);
    end
    @(negedge clock);
    n_checks++;
    if (rdy !== 1'b0 || result !== 32'd14) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got rdy=%b q=%0d need rdy=0 q=14", rdy, result);
    end
  endtask

  task automatic test_corner;
    logic [W-1:0] a_v[$];
    logic [W-1:0] b_v[$];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ee;
    int           lat;
`ifdef DIV_SIGNED_EN
    a_v = '{32'hFFFF_FF9C, 32'h8000_0000, 32'h0000_0000, 32'd100};
    b_v = '{32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
`else
    a_v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    b_v = '{32'd2,         32'hFFFF_FFFE, 32'h8000_0001};
`endif
    foreach (a_v[i]) begin
      model(a_v[i], b_v[i], eq, er, ee);
      launch(a_v[i], b_v[i]);
      wait_rdy(lat);
      n_checks++;
      if (lat !== LAT || result !== eq || remainder !== er || exc !== ee) begin
        n_fail++;
        $display("FAIL corner_%h_%h: got lat=%0d q=%h r=%h e=%b need lat=%0d q=%h r=%h e=%b",
                 a_v[i], b_v[i], lat, result, remainder, exc, LAT, eq, er, ee);
      end
    end
  endtask

  task automatic test_div0;
    int lat;
    launch(32'd5, 32'd0);
    wait_rdy(lat);
    n_checks++;
    if (lat !== LAT || result !== 0 || remainder !== 0 || exc !== 1'b1) begin
      n_fail++;
      $display("FAIL div0: got lat=%0d q=%h r=%h e=%b need lat=%0d q=0 r=0 e=1", lat, result, remainder, exc, LAT);
    end
    launch(32'd9, 32'd3);
    wait_rdy(lat);
    n_checks++;
    if (lat !== LAT || result !== 32'd3 || remainder !== 0 || exc !== 1'b0) begin
      n_fail++;
      $display("FAIL after_div0: got lat=%0d q=%h r=%h e=%b need lat=%0d q=3 r=0 e=0", lat, result, remainder, exc, LAT);
    end
  endtask

  task automatic test_restart;
    int           seen;
    int           first;
    logic [W-1:0] q_got;
    logic [W-1:0] r_got;
    seen  = 0;
    first = -1;
    q_got = '0;
    r_got = '0;
    @(negedge clock);
    op_a     = 32'd100;
    op_b     = 32'd7;
    ctrl_DIV = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 1)  ctrl_DIV = 1'b0;
      if (k == 10) begin op_a = 32'd50; op_b = 32'd5; ctrl_DIV = 1'b1; end
      if (k == 11) ctrl_DIV = 1'b0;
      if (rdy) begin
        seen++;
        if (first < 0) begin first = k; q_got = result; r_got = remainder; end
      end
    end
    n_checks++;
    if (seen !== 1 || first !== 10 + LAT) begin
      n_fail++;
      $display("FAIL restart_pulse: got %0d pulses first at %0d need 1 pulse at %0d", seen, first, 10 + LAT);
    end
    n_checks++;
    if (q_got !== 32'd10 || r_got !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_value: got q=%0d r=%0d need q=10 r=0", q_got, r_got);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(32'd1000, 32'd33);
    wait_rdy(lat);
    n_checks++;
    if (lat !== LAT || result !== 32'd30 || remainder !== 32'd10) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d need lat=%0d q=30 r=10", lat, result, remainder, LAT);
    end
    // Start the next op on the edge that ends the RDY pulse.
    launch_now(32'd77, 32'd8);
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_len: got rdy=%b need 0", rdy); end
    wait_rdy(lat);
    n_checks++;
    if (lat !== LAT || result !== 32'd9 || remainder !== 32'd5) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d need lat=%0d q=9 r=5", lat, result, remainder, LAT);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ee;
    int           lat;
    for (int n = 0; n < 30; n++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 15);
        1:       b = $urandom();
        2:       b = $urandom() >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 5) == 0) ? '0 : $urandom_range(1, 1000);
      endcase
      if (n % 7 == 3) a = a >> $urandom_range(0, 31);
      model(a, b, eq, er, ee);
      launch(a, b);
      wait_rdy(lat);
      n_checks++;
      if (lat !== LAT || result !== eq || remainder !== er || exc !== ee) begin
        n_fail++;
        $display("FAIL random_%0d %h/%h: got lat=%0d q=%h r=%h e=%b need lat=%0d q=%h r=%h e=%b",
                 n, a, b, lat, result, remainder, exc, LAT, eq, er, ee);
      end
    end
  endtask

  task automatic test_async_reset;
    int lat;
    int seen;
    launch(32'd9, 32'd3);
    wait_rdy(lat);
    launch(32'd100, 32'd7);
    repeat (14) @(negedge clock);
    n_checks++;
    if (result !== 32'd3) begin
      n_fail++;
      $display("FAIL hold_while_busy: got q=%0d need 3", result);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({result, remainder, exc, rdy} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h r=%h e=%b rdy=%b need all 0", result, remainder, exc, rdy);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    seen   = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (rdy) seen++;
    end
    n_checks++;
    if (seen !== 0 || result !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d pulses q=%h need 0 pulses q=0", seen, result);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_corner();
    test_div0();
    test_restart();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
